lcd_bus_receiver: RTL and testbench
===================================

# lcd_bus_receiver

- Responder end of the HD44780-style parallel LCD bus driven by `lcd_display_controller`.
- Samples EN/RS/RW/DATA, decodes instructions, keeps a 2×40 DDRAM image, a cursor address counter (AC), display flags and a busy timer, and answers status/data reads.
- Used as a synthesizable on-chip display model for bench checking and for mirroring LCD contents to a debug or UART path.

## Interface
- `SHORT_BUSY`, default 2_000: busy cycles after any non-clear/home latch (40 µs at 50 MHz).
- `LONG_BUSY`, default 76_000: busy cycles after clear (0x01) or home (0x02/0x03).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lcd_en`  in  1  bus enable. Asynchronous; 2-FF synchronized internally.
- `lcd_rs`  in  1  0 = instruction, 1 = data.
- `lcd_rw`  in  1  0 = write, 1 = read.
- `lcd_data`  in  8  bus byte.
- `disp_addr`  in  5  viewport index: 0–15 = line 1, 16–31 = line 2.
- `disp_char`  out  8  character at the viewport position. Registered, 1-cycle latency.
- `rd_data`  out  8  response to a read latch.
- `rd_valid`  out  1  1-cycle pulse when `rd_data` updates.
- `display_on`, `cursor_on`, `blink_on`  out  1 each  display control bits.
- `two_line`, `eight_bit`  out  1 each  function-set bits.
- `cursor_addr`  out  7  AC.
- `busy`  out  1  busy timer nonzero, or clear fill in progress.
- `err_busy`, `err_addr`  out  1 each  sticky error flags. Cleared only by reset.

## Operation
- **Reset values:** all outputs 0. `disp_char` = 0. DDRAM = 0x20 (reset runs the clear fill). Shift offset 0. Entry mode I/D = 1, S = 0.
- **Latch event:** falling edge of synchronized EN. RS, RW and DATA are sampled from their 2-FF copies on that same cycle.
- **Instruction decode (RS=0, RW=0)**, by highest set bit:
  - 0x80|a: set AC. Legal a: 0x00–0x27 or 0x40–0x67. Any other a → AC=0x00 and `err_addr` set.
  - 0x40–0x7F (CGRAM): accepted, no effect, short busy.
  - 0x20–0x3F: `eight_bit`=DL (bit4), `two_line`=N (bit3).
  - 0x10–0x1F: S/C=bit3, R/L=bit2.
    - S/C=0: AC ±1 with wrap.
    - S/C=1: shift offset ±1, mod 40.
  - 0x08–0x0F: D/C/B → `display_on`, `cursor_on`, `blink_on`.
  - 0x04–0x07: I/D=bit1, S=bit0.
  - 0x02/0x03: AC=0, offset=0. Long busy.
  - 0x01: AC=0, offset=0, I/D=1; FILL state writes 0x20 to all 80 entries, ascending, one per cycle. Long busy.
  - 0x00: ignored, no busy.
- **Data write (RS=1, RW=0):** DDRAM[AC] = byte. AC steps per I/D. If S=1, offset steps the same direction.
- **Status read (RS=0, RW=1):** `rd_data` = {busy, AC}. Allowed while busy. No busy started.
- **Data read (RS=1, RW=1):** `rd_data` = DDRAM[AC], then AC steps per I/D. Short busy.
- **AC wrap:**
  - increment: 0x27→0x40, 0x67→0x00.
  - decrement: 0x00→0x67, 0x40→0x27.
- **Viewport:** line L, column c maps to DDRAM line L, index (c + offset) mod 40.
- **FSM states:**
  - IDLE: latch → EXEC.
  - EXEC: one cycle. → FILL for clear, else → IDLE. Loads the busy timer.
  - FILL: 80 cycles → IDLE.
  - RESET: enters FILL, then IDLE.

## Timing
- EN sync: latch detected 3 cycles after the bus EN falling edge.
- EXEC effects (AC, flags, DDRAM write, `rd_data`/`rd_valid`) are visible 1 cycle after detection.
- Busy timer loads in EXEC and counts to 0. `busy` falls on the cycle the timer reaches 0.
- Clear: FILL (80 cycles) runs concurrently with the LONG_BUSY count. `busy` stays high until both finish.
- A `disp_char` read during FILL returns whatever the entry currently holds: 0x20 if already cleared, else the old value.
- Latch while busy: see Configuration.
- Reset mid-FILL: asynchronous abort; the RESET fill restarts from entry 0.

## Configuration
- **`LCD_RX_BUSY_CHECK_EN` defined:** any write/data-read latch while `busy`=1 is dropped and sets `err_busy`. Status reads are always honored.
- **Not defined:**
  - All latches execute and `err_busy` stays 0.
  - A clear during FILL restarts the fill at entry 0.
  - Busy timer reloads on every latch.

## Test plan
- **Power-up sequence:** reset, then 0x38, 0x0E, 0x01, 0x02, 0x06, then "----" → `eight_bit`=1, `two_line`=1, `display_on`=1, `cursor_on`=1, `blink_on`=0; viewport 0–3 = 0x2D; AC=0x04.
- **Positioned write:** 0x8A then "{0101}" → DDRAM 0x0A–0x0F = 7B 30 31 30 31 7D; AC=0x10.
- **Line-2 write and wrap:** 0xC0 then '+' → `disp_addr`=16 returns 0x2B. Set AC=0x67, write 'X' → AC=0x00. Decrement mode 0x04, write at 0x40 → AC=0x27.
- **Clear timing:** 0x01 → `busy` high for LONG_BUSY+1 cycles; all 32 viewport reads = 0x20 after `busy` falls; AC=0.
- **Busy violation, macro defined:** 0x01 then 'A' 100 cycles later → 'A' dropped, `err_busy`=1. Status read during the same busy window → `rd_data`=0x80, `rd_valid` pulse.
- **Shift and bad address:** 0x18 → viewport column 0 shows DDRAM index 1. 0xA8 → AC=0x00, `err_addr`=1.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// HD44780-style LCD bus responder: decodes latched bus cycles into a 2x40 DDRAM image,
// cursor/flag state and a busy timer. Define LCD_RX_BUSY_CHECK_EN to reject latches while busy.
module lcd_bus_receiver #(
   parameter int SHORT_BUSY = 2_000,
   parameter int LONG_BUSY  = 76_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_en,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] disp_addr,
   output logic [7:0] disp_char,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       two_line,
   output logic       eight_bit,
   output logic [6:0] cursor_addr,
   output logic       busy,
   output logic       err_busy,
   output logic       err_addr
);
   localparam int BMAX = (LONG_BUSY > SHORT_BUSY) ? LONG_BUSY : SHORT_BUSY;
   localparam int TW   = $clog2(BMAX + 1);

   typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_EXEC, ST_FILL} state_t;

   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
      logic [6:0] r;
      if (up) begin
         if (ac == 7'h27)      r = 7'h40;
         else if (ac == 7'h67) r = 7'h00;
         else                  r = ac + 7'd1;
      end else begin
         if (ac == 7'h00)      r = 7'h67;
         else if (ac == 7'h40) r = 7'h27;
         else                  r = ac - 7'd1;
      end
      return r;
   endfunction

   function automatic logic [5:0] ofs_step(input logic [5:0] ofs, input logic up);
      logic [5:0] r;
      if (up) r = (ofs == 6'd39) ? 6'd0 : ofs + 6'd1;
      else    r = (ofs == 6'd0) ? 6'd39 : ofs - 6'd1;
      return r;
   endfunction

   function automatic logic ac_legal(input logic [6:0] a);
      return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
   endfunction

   function automatic logic [6:0] ddram_idx(input logic [6:0] ac);
      return ac[6] ? (7'd40 + {1'b0, ac[5:0]}) : {1'b0, ac[5:0]};
   endfunction

   // Bus synchronizers; en_s3_q is the previous synchronized EN for edge detection.
   logic       en_s1_q, en_s2_q, en_s3_q;
   logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
   logic [7:0] data_s1_q, data_s2_q;

   state_t     state_q, state_d;
   logic       cmd_rs_q, cmd_rs_d, cmd_rw_q, cmd_rw_d;
   logic [7:0] cmd_data_q, cmd_data_d;
   logic [6:0] ac_q, ac_d;
   logic [5:0] ofs_q, ofs_d;
   logic       id_q, id_d, sh_q, sh_d;
   logic       disp_on_q, disp_on_d, cur_on_q, cur_on_d, blink_q, blink_d;
   logic       two_line_q, two_line_d, eight_bit_q, eight_bit_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [6:0] fill_idx_q, fill_idx_d;
   logic       fill_act_q, fill_act_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;
   logic [7:0] disp_char_q, disp_char_d;
   logic       err_busy_q, err_busy_d, err_addr_q, err_addr_d;

   logic [7:0] mem_q [0:79];
   logic       mem_we;
   logic [6:0] mem_wa;
   logic [7:0] mem_wd;

   logic       latch, core_busy, exec_busy, drop, accept, is_status;
   logic [5:0] vcol;
   logic [6:0] vidx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_s1_q   <= 1'b0;
         en_s2_q   <= 1'b0;
         en_s3_q   <= 1'b0;
         rs_s1_q   <= 1'b0;
         rs_s2_q   <= 1'b0;
         rw_s1_q   <= 1'b0;
         rw_s2_q   <= 1'b0;
         data_s1_q <= 8'h00;
         data_s2_q <= 8'h00;
      end else begin
         en_s1_q   <= lcd_en;
         en_s2_q   <= en_s1_q;
         en_s3_q   <= en_s2_q;
         rs_s1_q   <= lcd_rs;
         rs_s2_q   <= rs_s1_q;
         rw_s1_q   <= lcd_rw;
         rw_s2_q   <= rw_s1_q;
         data_s1_q <= lcd_data;
         data_s2_q <= data_s1_q;
      end
   end

   assign latch     = en_s3_q & ~en_s2_q;
   assign core_busy = (timer_q != '0) | fill_act_q;
   assign is_status = ~rs_s2_q & rw_s2_q;
`ifdef LCD_RX_BUSY_CHECK_EN
   assign drop = core_busy & ~is_status;
`else
   assign drop = 1'b0;
`endif
   assign accept = latch & ~drop & ((state_q == ST_IDLE) | (state_q == ST_FILL));
   // Status reads and the 0x00 no-op never raise busy, even during their EXEC cycle.
   assign exec_busy = (state_q == ST_EXEC) & ~(~cmd_rs_q & cmd_rw_q) &
                      ~(~cmd_rs_q & ~cmd_rw_q & (cmd_data_q == 8'h00));

   always_comb begin
      state_d     = state_q;
      cmd_rs_d    = cmd_rs_q;
      cmd_rw_d    = cmd_rw_q;
      cmd_data_d  = cmd_data_q;
      ac_d        = ac_q;
      ofs_d       = ofs_q;
      id_d        = id_q;
      sh_d        = sh_q;
      disp_on_d   = disp_on_q;
      cur_on_d    = cur_on_q;
      blink_d     = blink_q;
      two_line_d  = two_line_q;
      eight_bit_d = eight_bit_q;
      timer_d     = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
      fill_idx_d  = fill_idx_q;
      fill_act_d  = fill_act_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      err_busy_d  = err_busy_q | (latch & drop & ((state_q == ST_IDLE) | (state_q == ST_FILL)));
      err_addr_d  = err_addr_q;
      mem_we      = 1'b0;
      mem_wa      = fill_idx_q;
      mem_wd      = 8'h20;

      if (accept) begin
         cmd_rs_d   = rs_s2_q;
         cmd_rw_d   = rw_s2_q;
         cmd_data_d = data_s2_q;
      end

      case (state_q)
         ST_RESET: begin
            fill_idx_d = 7'd0;
            fill_act_d = 1'b1;
            state_d    = ST_FILL;
         end
         ST_IDLE: begin
            if (accept) state_d = ST_EXEC;
         end
         ST_FILL: begin
            if (accept) begin
               state_d = ST_EXEC;
            end else begin
               mem_we     = 1'b1;
               fill_idx_d = fill_idx_q + 7'd1;
               if (fill_idx_q == 7'd79) begin
                  fill_act_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_EXEC: begin
            if (!cmd_rs_q && !cmd_rw_q) begin
               // Instruction decode by highest set bit.
               if (cmd_data_q[7]) begin
                  if (ac_legal(cmd_data_q[6:0])) ac_d = cmd_data_q[6:0];
                  else begin
                     ac_d       = 7'h00;
                     err_addr_d = 1'b1;
                  end
                  timer_d = TW'(SHORT_BUSY);
               end else if (cmd_data_q[6]) begin
                  timer_d = TW'(SHORT_BUSY);
               end else if (cmd_data_q[5]) begin
                  eight_bit_d = cmd_data_q[4];
                  two_line_d  = cmd_data_q[3];
                  timer_d     = TW'(SHORT_BUSY);
               end else if (cmd_data_q[4]) begin
                  // Display shift left advances the viewport offset.
                  if (cmd_data_q[3]) ofs_d = ofs_step(ofs_q, ~cmd_data_q[2]);
                  else               ac_d  = ac_step(ac_q, cmd_data_q[2]);
                  timer_d = TW'(SHORT_BUSY);
               end else if (cmd_data_q[3]) begin
                  disp_on_d = cmd_data_q[2];
                  cur_on_d  = cmd_data_q[1];
                  blink_d   = cmd_data_q[0];
                  timer_d   = TW'(SHORT_BUSY);
               end else if (cmd_data_q[2]) begin
                  id_d    = cmd_data_q[1];
                  sh_d    = cmd_data_q[0];
                  timer_d = TW'(SHORT_BUSY);
               end else if (cmd_data_q[1]) begin
                  ac_d    = 7'h00;
                  ofs_d   = 6'd0;
                  timer_d = TW'(LONG_BUSY);
               end else if (cmd_data_q[0]) begin
                  ac_d       = 7'h00;
                  ofs_d      = 6'd0;
                  id_d       = 1'b1;
                  fill_idx_d = 7'd0;
                  fill_act_d = 1'b1;
                  timer_d    = TW'(LONG_BUSY);
               end
            end else if (cmd_rs_q && !cmd_rw_q) begin
               mem_we  = 1'b1;
               mem_wa  = ddram_idx(ac_q);
               mem_wd  = cmd_data_q;
               ac_d    = ac_step(ac_q, id_q);
               if (sh_q) ofs_d = ofs_step(ofs_q, id_q);
               timer_d = TW'(SHORT_BUSY);
            end else if (!cmd_rs_q && cmd_rw_q) begin
               rd_data_d  = {core_busy, ac_q};
               rd_valid_d = 1'b1;
            end else begin
               rd_data_d  = mem_q[ddram_idx(ac_q)];
               rd_valid_d = 1'b1;
               ac_d       = ac_step(ac_q, id_q);
               timer_d    = TW'(SHORT_BUSY);
            end
            state_d = fill_act_d ? ST_FILL : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      vcol = {2'b00, disp_addr[3:0]} + ofs_q;
      if (vcol >= 6'd40) vcol = vcol - 6'd40;
      vidx        = disp_addr[4] ? (7'd40 + {1'b0, vcol}) : {1'b0, vcol};
      disp_char_d = mem_q[vidx];
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         cmd_rs_q    <= 1'b0;
         cmd_rw_q    <= 1'b0;
         cmd_data_q  <= 8'h00;
         ac_q        <= 7'h00;
         ofs_q       <= 6'd0;
         id_q        <= 1'b1;
         sh_q        <= 1'b0;
         disp_on_q   <= 1'b0;
         cur_on_q    <= 1'b0;
         blink_q     <= 1'b0;
         two_line_q  <= 1'b0;
         eight_bit_q <= 1'b0;
         timer_q     <= '0;
         fill_idx_q  <= 7'd0;
         fill_act_q  <= 1'b0;
         rd_data_q   <= 8'h00;
         rd_valid_q  <= 1'b0;
         disp_char_q <= 8'h00;
         err_busy_q  <= 1'b0;
         err_addr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_rs_q    <= cmd_rs_d;
         cmd_rw_q    <= cmd_rw_d;
         cmd_data_q  <= cmd_data_d;
         ac_q        <= ac_d;
         ofs_q       <= ofs_d;
         id_q        <= id_d;
         sh_q        <= sh_d;
         disp_on_q   <= disp_on_d;
         cur_on_q    <= cur_on_d;
         blink_q     <= blink_d;
         two_line_q  <= two_line_d;
         eight_bit_q <= eight_bit_d;
         timer_q     <= timer_d;
         fill_idx_q  <= fill_idx_d;
         fill_act_q  <= fill_act_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         disp_char_q <= disp_char_d;
         err_busy_q  <= err_busy_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign disp_char   = disp_char_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign display_on  = disp_on_q;
   assign cursor_on   = cur_on_q;
   assign blink_on    = blink_q;
   assign two_line    = two_line_q;
   assign eight_bit   = eight_bit_q;
   assign cursor_addr = ac_q;
   assign busy        = core_busy | exec_busy;
   assign err_busy    = err_busy_q;
   assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed self-checking bench for lcd_bus_receiver with shortened busy timings.
module tb_lcd_bus_receiver;
   localparam int SB = 40;
   localparam int LB = 300;
`ifdef LCD_RX_BUSY_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lcd_en = 1'b0;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic [4:0] disp_addr = 5'd0;
   logic [7:0] disp_char, rd_data;
   logic       rd_valid, display_on, cursor_on, blink_on, two_line, eight_bit;
   logic [6:0] cursor_addr;
   logic       busy, err_busy, err_addr;

   int errors = 0;
   int checks = 0;
   int rdv_cnt = 0;

   lcd_bus_receiver #(.SHORT_BUSY(SB), .LONG_BUSY(LB)) dut (
      .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_data(lcd_data), .disp_addr(disp_addr), .disp_char(disp_char),
      .rd_data(rd_data), .rd_valid(rd_valid), .display_on(display_on),
      .cursor_on(cursor_on), .blink_on(blink_on), .two_line(two_line),
      .eight_bit(eight_bit), .cursor_addr(cursor_addr), .busy(busy),
      .err_busy(err_busy), .err_addr(err_addr)
   );

   always #10 clk = ~clk;

   always @(posedge clk) if (rd_valid) rdv_cnt <= rdv_cnt + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_not_busy();
      int n = 0;
      while (busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_timeout busy=%b required 0", busy);
      end
   endtask

   task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input logic wait_idle);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      lcd_en = 1'b0;
      repeat (6) @(negedge clk);
      if (wait_idle) wait_not_busy();
   endtask

   task automatic view(input logic [4:0] a, output logic [7:0] c);
      @(negedge clk);
      disp_addr = a;
      @(negedge clk);
      c = disp_char;
   endtask

   task automatic test_reset();
      logic [7:0] c;
      repeat (3) @(negedge clk);
      checks++;
      if ({disp_char, rd_data, rd_valid, display_on, cursor_on, blink_on, two_line, eight_bit,
           cursor_addr, busy, err_busy, err_addr} !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs disp=%h rd=%h ac=%h busy=%b got nonzero, required all 0",
                  disp_char, rd_data, cursor_addr, busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_fill_busy busy=%b required 1", busy); end
      wait_not_busy();
      view(5'd0, c);
      checks++;
      if (c !== 8'h20) begin errors++; $display("FAIL reset_fill_v0 got %h required 20", c); end
      view(5'd31, c);
      checks++;
      if (c !== 8'h20) begin errors++; $display("FAIL reset_fill_v31 got %h required 20", c); end
   endtask

   task automatic test_power_up();
      logic [7:0] c;
      xfer(0, 0, 8'h38, 1);
      xfer(0, 0, 8'h0E, 1);
      xfer(0, 0, 8'h01, 1);
      xfer(0, 0, 8'h02, 1);
      xfer(0, 0, 8'h06, 1);
      for (int i = 0; i < 4; i++) xfer(1, 0, 8'h2D, 1);
      checks++;
      if ({eight_bit, two_line, display_on, cursor_on, blink_on} !== 5'b11110) begin
         errors++;
         $display("FAIL pwr_flags got %b required 11110",
                  {eight_bit, two_line, display_on, cursor_on, blink_on});
      end
      for (int i = 0; i < 4; i++) begin
         view(5'(i), c);
         checks++;
         if (c !== 8'h2D) begin errors++; $display("FAIL pwr_view%0d got %h required 2d", i, c); end
      end
      checks++;
      if (cursor_addr !== 7'h04) begin errors++; $display("FAIL pwr_ac got %h required 04", cursor_addr); end
   endtask

   task automatic test_positioned();
      logic [7:0] exp [6];
      logic [7:0] c;
      exp = '{8'h7B, 8'h30, 8'h31, 8'h30, 8'h31, 8'h7D};
      xfer(0, 0, 8'h8A, 1);
      for (int i = 0; i < 6; i++) xfer(1, 0, exp[i], 1);
      for (int i = 0; i < 6; i++) begin
         view(5'(10 + i), c);
         checks++;
         if (c !== exp[i]) begin errors++; $display("FAIL pos_view%0d got %h required %h", 10 + i, c, exp[i]); end
      end
      checks++;
      if (cursor_addr !== 7'h10) begin errors++; $display("FAIL pos_ac got %h required 10", cursor_addr); end
   endtask

   task automatic test_line2_wrap();
      logic [7:0] c;
      xfer(0, 0, 8'hC0, 1);
      xfer(1, 0, 8'h2B, 1);
      view(5'd16, c);
      checks++;
      if (c !== 8'h2B) begin errors++; $display("FAIL l2_view16 got %h required 2b", c); end
      checks++;
      if (cursor_addr !== 7'h41) begin errors++; $display("FAIL l2_ac got %h required 41", cursor_addr); end
      xfer(0, 0, 8'hE7, 1);
      xfer(1, 0, 8'h58, 1);
      checks++;
      if (cursor_addr !== 7'h00) begin errors++; $display("FAIL wrap_inc_ac got %h required 00", cursor_addr); end
      xfer(0, 0, 8'h04, 1);
      xfer(0, 0, 8'hC0, 1);
      xfer(1, 0, 8'h59, 1);
      checks++;
      if (cursor_addr !== 7'h27) begin errors++; $display("FAIL wrap_dec_ac got %h required 27", cursor_addr); end
      view(5'd16, c);
      checks++;
      if (c !== 8'h59) begin errors++; $display("FAIL dec_view16 got %h required 59", c); end
      xfer(0, 0, 8'h06, 1);
   endtask

   task automatic test_data_read();
      int c0;
      xfer(0, 0, 8'h85, 1);
      xfer(1, 0, 8'h51, 1);
      xfer(0, 0, 8'h85, 1);
      c0 = rdv_cnt;
      xfer(1, 1, 8'h00, 1);
      checks++;
      if (rd_data !== 8'h51) begin errors++; $display("FAIL dread_data got %h required 51", rd_data); end
      checks++;
      if (cursor_addr !== 7'h06) begin errors++; $display("FAIL dread_ac got %h required 06", cursor_addr); end
      checks++;
      if (rdv_cnt - c0 !== 1) begin errors++; $display("FAIL dread_pulses got %0d required 1", rdv_cnt - c0); end
      c0 = rdv_cnt;
      xfer(0, 1, 8'h00, 0);
      checks++;
      if (rd_data !== 8'h06) begin errors++; $display("FAIL sread_idle got %h required 06", rd_data); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL sread_nobusy busy=%b required 0", busy); end
      checks++;
      if (rdv_cnt - c0 !== 1) begin errors++; $display("FAIL sread_pulses got %0d required 1", rdv_cnt - c0); end
   endtask

   task automatic test_clear_timing();
      int hi = 0;
      bit seen = 0;
      logic [7:0] c;
      @(negedge clk);
      lcd_rs = 0; lcd_rw = 0; lcd_data = 8'h01; lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      lcd_en = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (busy === 1'b1) begin hi++; seen = 1; end
         else if (seen) break;
      end
      checks++;
      if (hi !== LB + 1) begin errors++; $display("FAIL clear_busy_len got %0d required %0d", hi, LB + 1); end
      for (int i = 0; i < 32; i++) begin
         view(5'(i), c);
         checks++;
         if (c !== 8'h20) begin errors++; $display("FAIL clear_view%0d got %h required 20", i, c); end
      end
      checks++;
      if (cursor_addr !== 7'h00) begin errors++; $display("FAIL clear_ac got %h required 00", cursor_addr); end
   endtask

   task automatic test_busy_violation();
      int c0;
      logic [7:0] c;
      xfer(0, 0, 8'h01, 0);
      repeat (100) @(negedge clk);
      xfer(1, 0, 8'h41, 0);
      c0 = rdv_cnt;
      xfer(0, 1, 8'h00, 0);
      checks++;
      if (rd_data !== (CHK ? 8'h80 : 8'h81)) begin
         errors++;
         $display("FAIL bv_status got %h required %h", rd_data, CHK ? 8'h80 : 8'h81);
      end
      checks++;
      if (rdv_cnt - c0 !== 1) begin errors++; $display("FAIL bv_pulses got %0d required 1", rdv_cnt - c0); end
      wait_not_busy();
      checks++;
      if (err_busy !== CHK) begin errors++; $display("FAIL bv_err_busy got %b required %b", err_busy, CHK); end
      view(5'd0, c);
      checks++;
      if (c !== (CHK ? 8'h20 : 8'h41)) begin
         errors++;
         $display("FAIL bv_view0 got %h required %h", c, CHK ? 8'h20 : 8'h41);
      end
      checks++;
      if (cursor_addr !== (CHK ? 7'h00 : 7'h01)) begin
         errors++;
         $display("FAIL bv_ac got %h required %h", cursor_addr, CHK ? 7'h00 : 7'h01);
      end
   endtask

   task automatic test_shift_addr();
      logic [7:0] c;
      xfer(0, 0, 8'h80, 1);
      xfer(1, 0, 8'h61, 1);
      xfer(1, 0, 8'h62, 1);
      xfer(0, 0, 8'h18, 1);
      view(5'd0, c);
      checks++;
      if (c !== 8'h62) begin errors++; $display("FAIL shl_view0 got %h required 62", c); end
      xfer(0, 0, 8'h1C, 1);
      view(5'd0, c);
      checks++;
      if (c !== 8'h61) begin errors++; $display("FAIL shr_view0 got %h required 61", c); end
      xfer(0, 0, 8'h1C, 1);
      view(5'd1, c);
      checks++;
      if (c !== 8'h61) begin errors++; $display("FAIL shr_wrap_view1 got %h required 61", c); end
      view(5'd0, c);
      checks++;
      if (c !== 8'h20) begin errors++; $display("FAIL shr_wrap_view0 got %h required 20", c); end
      xfer(0, 0, 8'h10, 1);
      checks++;
      if (cursor_addr !== 7'h01) begin errors++; $display("FAIL curl_ac got %h required 01", cursor_addr); end
      xfer(0, 0, 8'h80, 1);
      xfer(0, 0, 8'h10, 1);
      checks++;
      if (cursor_addr !== 7'h67) begin errors++; $display("FAIL curl_wrap_ac got %h required 67", cursor_addr); end
      checks++;
      if (err_addr !== 1'b0) begin errors++; $display("FAIL err_addr_pre got %b required 0", err_addr); end
      xfer(0, 0, 8'hA8, 1);
      checks++;
      if (cursor_addr !== 7'h00) begin errors++; $display("FAIL bad_addr_ac got %h required 00", cursor_addr); end
      checks++;
      if (err_addr !== 1'b1) begin errors++; $display("FAIL bad_addr_err got %b required 1", err_addr); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_positioned();
      test_line2_wrap();
      test_data_read();
      test_clear_timing();
      test_busy_violation();
      test_shift_addr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
